// File: rtl/game_sequencer.sv
// Breakout-style game sequencer: ball motion, wall/paddle/brick collisions, lives and score.
// Define PADDLE_STEER_EN to let the paddle hit position steer the ball's horizontal direction.
module game_sequencer #(
    parameter int BALL_STEP  = 2,
    parameter int LIVES_INIT = 3,
    parameter int PADDLE_Y   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] paddle_x,
    input  logic       brick_ack,
    input  logic       brick_hit,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       brick_req,
    output logic [2:0] brick_row,
    output logic [3:0] brick_col,
    output logic [1:0] lives,
    output logic [5:0] score,
    output logic       new_game,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [2:0] {IDLE, MOVE, CHECK, OVER, WON} state_t;

`ifdef PADDLE_STEER_EN
    localparam bit STEER_EN = 1'b1;
`else
    localparam bit STEER_EN = 1'b0;
`endif

    localparam logic signed [10:0] STEP_S = 11'(BALL_STEP);
    localparam logic signed [10:0] X_MIN  = 11'sd144;
    localparam logic signed [10:0] X_MAX  = 11'sd783;
    localparam logic signed [10:0] Y_MIN  = 11'sd34;
    localparam logic signed [10:0] Y_MISS = 11'sd514;
    localparam logic signed [10:0] Y_PAD  = 11'(PADDLE_Y - 6);
    localparam logic [9:0]         Y_REST = 10'(PADDLE_Y - 6);
    localparam logic [9:0]         X_RST  = 10'd450;
    localparam logic [1:0]         LIVES_RST = 2'(LIVES_INIT);

    state_t      state_q;
    logic [9:0]  ballX_q, ballY_q;
    logic        dx_q, dy_q;
    logic [1:0]  lives_q;
    logic [5:0]  score_q;
    logic        brickReq_q;
    logic [2:0]  brickRow_q;
    logic [3:0]  brickCol_q;
    logic        newGame_q, gameOver_q, gameWon_q;
    logic        pending_q;

    logic signed [10:0] xSum_d, ySum_d, paddleDiff_d;
    logic [9:0]  nextX_d, nextY_d;
    logic        nextDx_d, nextDy_d;
    logic        paddleHit_d, miss_d, inGrid_d, moveTick_d;
    logic [2:0]  row_d;
    logic [3:0]  col_d;

    // dx/dy: 1 means increasing coordinate (right / down on screen).
    always_comb begin
        xSum_d   = dx_q ? ($signed({1'b0, ballX_q}) + STEP_S) : ($signed({1'b0, ballX_q}) - STEP_S);
        ySum_d   = dy_q ? ($signed({1'b0, ballY_q}) + STEP_S) : ($signed({1'b0, ballY_q}) - STEP_S);
        nextDx_d = dx_q;
        nextDy_d = dy_q;
        nextX_d  = xSum_d[9:0];
        nextY_d  = ySum_d[9:0];

        if (xSum_d <= X_MIN) begin
            nextX_d  = 10'd144;
            nextDx_d = 1'b1;
        end else if (xSum_d >= X_MAX) begin
            nextX_d  = 10'd783;
            nextDx_d = 1'b0;
        end

        if (ySum_d <= Y_MIN) begin
            nextY_d  = 10'd34;
            nextDy_d = 1'b1;
        end

        paddleDiff_d = $signed({1'b0, nextX_d}) - $signed({1'b0, paddle_x});
        paddleHit_d  = dy_q && (ySum_d >= Y_PAD) &&
                       (paddleDiff_d >= -11'sd25) && (paddleDiff_d <= 11'sd25);

        if (paddleHit_d) begin
            nextY_d  = Y_REST;
            nextDy_d = 1'b0;
            if (STEER_EN && (paddleDiff_d < -11'sd8)) begin
                nextDx_d = 1'b0;
            end else if (STEER_EN && (paddleDiff_d > 11'sd8)) begin
                nextDx_d = 1'b1;
            end
        end

        miss_d     = !paddleHit_d && (ySum_d >= Y_MISS);
        inGrid_d   = nextY_d < 10'd159;
        moveTick_d = frame_tick | pending_q;

        // Grid lookup by threshold comparison: rows are 25 px from 34, columns 53 px from 144.
        if (nextY_d < 10'd59) begin
            row_d = 3'd0;
        end else if (nextY_d < 10'd84) begin
            row_d = 3'd1;
        end else if (nextY_d < 10'd109) begin
            row_d = 3'd2;
        end else if (nextY_d < 10'd134) begin
            row_d = 3'd3;
        end else begin
            row_d = 3'd4;
        end

        col_d = 4'd0;
        for (int i = 1; i < 12; i++) begin
            if (nextX_d >= 10'(144 + 53 * i)) begin
                col_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ballX_q    <= X_RST;
            ballY_q    <= Y_REST;
            dx_q       <= 1'b1;
            dy_q       <= 1'b0;
            lives_q    <= LIVES_RST;
            score_q    <= 6'd0;
            brickReq_q <= 1'b0;
            brickRow_q <= 3'd0;
            brickCol_q <= 4'd0;
            newGame_q  <= 1'b0;
            gameOver_q <= 1'b0;
            gameWon_q  <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            newGame_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ballX_q   <= paddle_x;
                    ballY_q   <= Y_REST;
                    pending_q <= 1'b0;
                    if (start) begin
                        dx_q    <= 1'b1;
                        dy_q    <= 1'b0;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    if (moveTick_d) begin
                        pending_q <= 1'b0;
                        ballX_q   <= nextX_d;
                        ballY_q   <= nextY_d;
                        dx_q      <= nextDx_d;
                        dy_q      <= nextDy_d;
                        if (miss_d) begin
                            lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                            if (lives_q <= 2'd1) begin
                                state_q    <= OVER;
                                gameOver_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (inGrid_d) begin
                            brickReq_q <= 1'b1;
                            brickRow_q <= row_d;
                            brickCol_q <= col_d;
                            state_q    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // Only one deferred tick is remembered; extra ticks are dropped.
                    if (frame_tick) begin
                        pending_q <= 1'b1;
                    end
                    if (brick_ack) begin
                        brickReq_q <= 1'b0;
                        if (brick_hit) begin
                            dy_q    <= ~dy_q;
                            score_q <= score_q + 6'd1;
                            if (score_q == 6'd59) begin
                                state_q   <= WON;
                                gameWon_q <= 1'b1;
                            end else begin
                                state_q <= MOVE;
                            end
                        end else begin
                            state_q <= MOVE;
                        end
                    end
                end
                OVER, WON: begin
                    if (start) begin
                        newGame_q  <= 1'b1;
                        lives_q    <= LIVES_RST;
                        score_q    <= 6'd0;
                        gameOver_q <= 1'b0;
                        gameWon_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ball_x    = ballX_q;
    assign ball_y    = ballY_q;
    assign brick_req = brickReq_q;
    assign brick_row = brickRow_q;
    assign brick_col = brickCol_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign new_game  = newGame_q;
    assign game_over = gameOver_q;
    assign game_won  = gameWon_q;

endmodule
